// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit-side controllers.
package uart_ctrl_pkg;

    typedef enum logic {S_IDLE, S_SEND} tx_arb_state_t;

    localparam int UART_BYTE_W      = 8;
    localparam int DEF_WORD_BYTES   = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr, moves upward and wraps.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        int   j;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte sender among NREQ word requesters, round-robin, LSB first.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter  int NREQ       = 2,
    parameter  int WORD_BYTES = DEF_WORD_BYTES,
    localparam int IW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [IW-1:0]        grant_id
);

    localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(WORD_BYTES - 1);

    tx_arb_state_t state_reg, state_next;
    logic [IW-1:0] ptr_reg, ptr_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   shift_reg, shift_next;
    logic          tx_valid_reg, tx_valid_next;
    logic [7:0]    tx_data_reg, tx_data_next;
    logic          busy_reg, busy_next;
    logic [IW-1:0] grant_id_reg, grant_id_next;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic [31:0]     words [NREQ];
    logic [31:0]     granted_word;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign words[gi] = req_data[32*gi +: 32];
    end

    rr_arbiter #(.N(NREQ)) u_rr (
        .req     (req_valid),
        .ptr     (ptr_reg),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign granted_word = words[gnt_idx];
    assign req_ready    = (state_reg == S_IDLE) ? gnt : '0;
    assign tx_valid     = tx_valid_reg;
    assign tx_data      = tx_data_reg;
    assign busy         = busy_reg;
    assign grant_id     = grant_id_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= S_IDLE;
            ptr_reg      <= '0;
            cnt_reg      <= '0;
            shift_reg    <= '0;
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
            busy_reg     <= 1'b0;
            grant_id_reg <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            cnt_reg      <= cnt_next;
            shift_reg    <= shift_next;
            tx_valid_reg <= tx_valid_next;
            tx_data_reg  <= tx_data_next;
            busy_reg     <= busy_next;
            grant_id_reg <= grant_id_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        cnt_next      = cnt_reg;
        shift_next    = shift_reg;
        tx_valid_next = tx_valid_reg;
        tx_data_next  = tx_data_reg;
        busy_next     = busy_reg;
        grant_id_next = grant_id_reg;
        case (state_reg)
            S_IDLE: begin
                if (|req_valid) begin
                    shift_next    = granted_word;
                    grant_id_next = gnt_idx;
                    tx_data_next  = granted_word[UART_BYTE_W-1:0];
                    tx_valid_next = 1'b1;
                    busy_next     = 1'b1;
                    cnt_next      = '0;
                    ptr_next      = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_next    = S_SEND;
                end
            end
            S_SEND: begin
                // The shift register keeps the latched word, so later req_data changes never leak in.
                if (tx_valid_reg && tx_ready) begin
                    if (cnt_reg == LAST_BYTE) begin
                        tx_valid_next = 1'b0;
                        busy_next     = 1'b0;
                        state_next    = S_IDLE;
                    end else begin
                        shift_next   = shift_reg >> UART_BYTE_W;
                        tx_data_next = shift_reg[2*UART_BYTE_W-1:UART_BYTE_W];
                        cnt_next     = cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: two instances (2x4-byte and 3x1-byte) driven against sender models.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    logic [1:0]  req_valid_a;
    logic [63:0] req_data_a;
    logic [1:0]  req_ready_a;
    logic        tx_valid_a;
    logic [7:0]  tx_data_a;
    logic        tx_ready_a;
    logic        busy_a;
    logic [0:0]  grant_id_a;

    logic [2:0]  req_valid_b;
    logic [95:0] req_data_b;
    logic [2:0]  req_ready_b;
    logic        tx_valid_b;
    logic [7:0]  tx_data_b;
    logic        tx_ready_b;
    logic        busy_b;
    logic [1:0]  grant_id_b;

    uart_tx_arbiter #(.NREQ(2), .WORD_BYTES(4)) dut_a (
        .clk(clk), .rstn(rstn), .req_valid(req_valid_a), .req_data(req_data_a),
        .req_ready(req_ready_a), .tx_valid(tx_valid_a), .tx_data(tx_data_a),
        .tx_ready(tx_ready_a), .busy(busy_a), .grant_id(grant_id_a)
    );

    uart_tx_arbiter #(.NREQ(3), .WORD_BYTES(1)) dut_b (
        .clk(clk), .rstn(rstn), .req_valid(req_valid_b), .req_data(req_data_b),
        .req_ready(req_ready_b), .tx_valid(tx_valid_b), .tx_data(tx_data_b),
        .tx_ready(tx_ready_b), .busy(busy_b), .grant_id(grant_id_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt_a = 0, gnt_cnt_a = 0, hs_cnt_b = 0, gnt_cnt_b = 0;
    int sbusy_a = 0, sbusy_b = 0;
    logic hs_a = 1'b0, hs_b = 1'b0;
    logic hold_a = 1'b0;
    logic [7:0] exp_byte_a[$];
    logic [7:0] exp_byte_b[$];
    int exp_gnt_a[$];
    int exp_gnt_b[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2idx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Monitor at negedge, sender model (10 busy cycles per byte) just after posedge.
    initial begin : mon_a
        tx_ready_a = 1'b1;
        forever begin
            @(negedge clk);
            hs_a = rstn && tx_valid_a && tx_ready_a;
            if (hs_a) begin
                hs_cnt_a++;
                $display("[%0t] A byte %02h from requester %0d", $time, tx_data_a, grant_id_a);
                if (exp_byte_a.size() == 0) check("a_extra_byte", {24'h0, tx_data_a}, 32'h100);
                else check("a_byte", {24'h0, tx_data_a}, {24'h0, exp_byte_a.pop_front()});
            end
            if (rstn && req_ready_a != 2'b00) begin
                gnt_cnt_a++;
                $display("[%0t] A grant req_ready=%b", $time, req_ready_a);
                check("a_onehot", $countones(req_ready_a), 1);
                if (exp_gnt_a.size() == 0) check("a_extra_grant", oh2idx({6'h0, req_ready_a}), 32'hFF);
                else check("a_grant", oh2idx({6'h0, req_ready_a}), exp_gnt_a.pop_front());
            end
            @(posedge clk); #1;
            if (hs_a) sbusy_a = 10; else if (sbusy_a > 0) sbusy_a--;
            tx_ready_a = (sbusy_a == 0) && !hold_a;
        end
    end

    initial begin : mon_b
        tx_ready_b = 1'b1;
        forever begin
            @(negedge clk);
            hs_b = rstn && tx_valid_b && tx_ready_b;
            if (hs_b) begin
                hs_cnt_b++;
                $display("[%0t] B byte %02h from requester %0d", $time, tx_data_b, grant_id_b);
                if (exp_byte_b.size() == 0) check("b_extra_byte", {24'h0, tx_data_b}, 32'h100);
                else check("b_byte", {24'h0, tx_data_b}, {24'h0, exp_byte_b.pop_front()});
            end
            if (rstn && req_ready_b != 3'b000) begin
                gnt_cnt_b++;
                $display("[%0t] B grant req_ready=%b", $time, req_ready_b);
                check("b_onehot", $countones(req_ready_b), 1);
                if (exp_gnt_b.size() == 0) check("b_extra_grant", oh2idx({5'h0, req_ready_b}), 32'hFF);
                else check("b_grant", oh2idx({5'h0, req_ready_b}), exp_gnt_b.pop_front());
            end
            @(posedge clk); #1;
            if (hs_b) sbusy_b = 3; else if (sbusy_b > 0) sbusy_b--;
            tx_ready_b = (sbusy_b == 0);
        end
    end

    task automatic push_word_a(input logic [31:0] w);
        for (int k = 0; k < 4; k++) exp_byte_a.push_back(w[8*k +: 8]);
    endtask

    task automatic put_word_a(input int idx, input logic [31:0] w);
        int base, t;
        req_data_a[32*idx +: 32] = w;
        req_valid_a[idx] = 1'b1;
        exp_gnt_a.push_back(idx);
        push_word_a(w);
        base = gnt_cnt_a;
        t = 0;
        while (gnt_cnt_a == base && t < 500) begin tick(); t++; end
        req_valid_a[idx] = 1'b0;
        check("a_grant_timeout", {31'h0, t < 500}, 1);
    endtask

    task automatic wait_idle_a();
        int t = 0;
        while ((exp_byte_a.size() != 0 || busy_a) && t < 3000) begin tick(); t++; end
        check("a_idle_timeout", {31'h0, t < 3000}, 1);
    endtask

    task automatic wait_gnt_b(input int target);
        int t = 0;
        while (gnt_cnt_b < target && t < 500) begin tick(); t++; end
        check("b_grant_timeout", {31'h0, t < 500}, 1);
    endtask

    task automatic wait_idle_b();
        int t = 0;
        while ((exp_byte_b.size() != 0 || busy_b) && t < 1000) begin tick(); t++; end
        check("b_idle_timeout", {31'h0, t < 1000}, 1);
    endtask

    initial begin : stim
        int base, t;
        rstn = 1'b1;
        req_valid_a = '0; req_data_a = '0;
        req_valid_b = '0; req_data_b = '0;
        #1 rstn = 1'b0;
        repeat (3) tick();
        check("rst_tx_valid", {31'h0, tx_valid_a}, 0);
        check("rst_tx_data", {24'h0, tx_data_a}, 0);
        check("rst_busy", {31'h0, busy_a}, 0);
        check("rst_grant_id", {31'h0, grant_id_a}, 0);
        check("rst_b_tx_valid", {31'h0, tx_valid_b}, 0);
        rstn = 1'b1;
        tick();

        // Fairness: both requesters valid continuously.
        req_data_a = {32'h00000022, 32'h00000011};
        req_valid_a = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_gnt_a.push_back(i % 2);
            push_word_a((i % 2 == 0) ? 32'h00000011 : 32'h00000022);
        end
        base = gnt_cnt_a; t = 0;
        while (gnt_cnt_a - base < 4 && t < 2000) begin tick(); t++; end
        req_valid_a = 2'b00;
        check("a_fair_timeout", {31'h0, t < 2000}, 1);
        wait_idle_a();

        // Single word, busy spans exactly four handshakes.
        base = hs_cnt_a;
        put_word_a(0, 32'hDEADBEEF);
        @(negedge clk);
        check("a_busy_on", {31'h0, busy_a}, 1);
        check("a_valid_on", {31'h0, tx_valid_a}, 1);
        check("a_gid_single", {31'h0, grant_id_a}, 0);
        t = 0;
        while (busy_a && t < 1000) begin @(negedge clk); t++; end
        check("a_busy_len", hs_cnt_a - base, 4);
        wait_idle_a();

        // Backpressure: sender not ready for 50 cycles.
        hold_a = 1'b1;
        tick();
        put_word_a(0, 32'h01020304);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("a_bp_valid", {31'h0, tx_valid_a}, 1);
            check("a_bp_data", {24'h0, tx_data_a}, 32'h04);
        end
        tick();
        hold_a = 1'b0;
        wait_idle_a();

        // Owner rewrites its data mid-word.
        base = hs_cnt_a;
        put_word_a(0, 32'h11223344);
        t = 0;
        while (hs_cnt_a - base < 1 && t < 500) begin tick(); t++; end
        req_data_a[31:0] = 32'hFFFFFFFF;
        wait_idle_a();

        // Reset after the second handshake drops the rest of the word.
        base = hs_cnt_a;
        put_word_a(1, 32'hAABBCCDD);
        t = 0;
        while (hs_cnt_a - base < 2 && t < 500) begin tick(); t++; end
        check("a_gid_pre_rst", {31'h0, grant_id_a}, 1);
        rstn = 1'b0;
        #1;
        check("a_rst_valid", {31'h0, tx_valid_a}, 0);
        check("a_rst_busy", {31'h0, busy_a}, 0);
        check("a_rst_gid", {31'h0, grant_id_a}, 0);
        check("a_rst_data", {24'h0, tx_data_a}, 0);
        exp_byte_a.delete();
        repeat (3) tick();
        check("a_rst_hold_valid", {31'h0, tx_valid_a}, 0);
        rstn = 1'b1;
        tick();
        put_word_a(0, 32'h55667788);
        wait_idle_a();

        // Three requesters, one byte per word, pointer wrap.
        req_data_b = {32'h123456A2, 32'h00000000, 32'h9ABCDEB0};
        req_valid_b = 3'b100;
        exp_gnt_b.push_back(2); exp_byte_b.push_back(8'hA2);
        base = gnt_cnt_b;
        wait_gnt_b(base + 1);
        req_valid_b[2] = 1'b0;
        wait_idle_b();
        req_valid_b = 3'b101;
        exp_gnt_b.push_back(0); exp_byte_b.push_back(8'hB0);
        exp_gnt_b.push_back(2); exp_byte_b.push_back(8'hA2);
        base = gnt_cnt_b;
        wait_gnt_b(base + 1);
        req_valid_b[0] = 1'b0;
        wait_gnt_b(base + 2);
        req_valid_b[2] = 1'b0;
        wait_idle_b();
        repeat (5) tick();

        check("a_gnt_left", exp_gnt_a.size(), 0);
        check("b_gnt_left", exp_gnt_b.size(), 0);
        check("b_byte_left", exp_byte_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
